// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase generator.
// The dither LFSR constants are only used when DDS_PHASE_DITHER_EN is defined.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2,
        STOP  = 2'd3
    } dds_state_t;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int CFG_PHASE_DW = 16;
    localparam int CFG_STEP_DW  = 16;
    localparam int CFG_COUNT_DW = 16;

    // freq sweeps and len counts down during operation; step and offset stay fixed
    typedef struct packed {
        logic [CFG_PHASE_DW-1:0] freq;
        logic [CFG_STEP_DW-1:0]  step;
        logic [CFG_COUNT_DW-1:0] len;
        logic [CFG_PHASE_DW-1:0] offset;
    } dds_cfg_t;

endpackage

// File: rtl/dds_phase_lfsr.sv
// 16-bit Fibonacci LFSR supplying phase dither; advances once per taken sample.
module dds_phase_lfsr
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_next
);

    assign state_next = {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LFSR_SEED;
        end else if (advance) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator / NCO with linear sweep, phase offset and AXI-stream output.
// Optional LSB dither enabled by defining DDS_PHASE_DITHER_EN.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int PHASE_DW  = CFG_PHASE_DW,
    parameter int STEP_DW   = CFG_STEP_DW,
    parameter int COUNT_DW  = CFG_COUNT_DW,
    parameter int DITHER_DW = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PHASE_DW-1:0] cfg_freq,
    input  logic [STEP_DW-1:0]  cfg_freq_step,
    input  logic [COUNT_DW-1:0] cfg_sweep_len,
    input  logic [PHASE_DW-1:0] cfg_phase_offset,
    output logic [PHASE_DW-1:0] m_axis_phase_tdata,
    output logic                m_axis_phase_tvalid,
    input  logic                m_axis_phase_tready,
    output logic                busy,
    output logic                sweep_done
);

    dds_state_t          state;
    dds_cfg_t            cfg;
    dds_cfg_t            new_cfg;
    dds_cfg_t            start_cfg;
    logic [PHASE_DW-1:0] acc;
    logic [PHASE_DW-1:0] start_acc;
    logic [PHASE_DW-1:0] acc_adv;
    logic [PHASE_DW-1:0] step_ext;
    logic [PHASE_DW-1:0] dither_cur;
    logic [PHASE_DW-1:0] dither_nxt;
    logic                take;
    logic                sweeping;
    logic                last_step;

    assign take      = m_axis_phase_tvalid & m_axis_phase_tready;
    assign sweeping  = (cfg.len != '0);
    assign last_step = (cfg.len == CFG_COUNT_DW'(1));
    assign acc_adv   = acc + cfg.freq;
    assign step_ext  = PHASE_DW'(signed'(cfg.step));
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign new_cfg = '{freq: cfg_freq, step: cfg_freq_step, len: cfg_sweep_len, offset: cfg_phase_offset};

    // A config beat and enable in the same IDLE cycle start from the new values
    always_comb begin
        start_cfg = cfg;
        start_acc = acc;
        if (cfg_valid) begin
            start_cfg = new_cfg;
            start_acc = '0;
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] lfsr_next;

    dds_phase_lfsr u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .advance    (take),
        .state      (lfsr_state),
        .state_next (lfsr_next)
    );

    assign dither_cur = PHASE_DW'(lfsr_state[DITHER_DW-1:0]);
    assign dither_nxt = PHASE_DW'(lfsr_next[DITHER_DW-1:0]);
`else
    assign dither_cur = '0;
    assign dither_nxt = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            cfg                 <= '0;
            acc                 <= '0;
            m_axis_phase_tdata  <= '0;
            m_axis_phase_tvalid <= 1'b0;
            sweep_done          <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid) begin
                    cfg <= new_cfg;
                    acc <= '0;
                end
                if (enable) begin
                    state               <= (start_cfg.len != '0) ? SWEEP : RUN;
                    m_axis_phase_tvalid <= 1'b1;
                    m_axis_phase_tdata  <= start_acc + start_cfg.offset + dither_cur;
                end
            end else if (take) begin
                // A non-zero count means sweep updates are still due, including in STOP
                acc <= acc_adv;
                if (sweeping) begin
                    cfg.freq <= cfg.freq + step_ext;
                    cfg.len  <= cfg.len - 1'b1;
                    if (last_step) begin
                        sweep_done <= 1'b1;
                    end
                end
                if (state == STOP) begin
                    m_axis_phase_tvalid <= 1'b0;
                    state               <= IDLE;
                end else begin
                    m_axis_phase_tdata <= acc_adv + cfg.offset + dither_nxt;
                    if (!enable) begin
                        state <= STOP;
                    end else if (sweeping && last_step) begin
                        state <= RUN;
                    end
                end
            end else if (state != STOP && !enable) begin
                state <= STOP;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboard bench for dds_phase_gen: a word-level phase model queues expected
// samples and a negedge monitor checks each taken beat against the queue.
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_freq;
    logic [15:0] cfg_freq_step;
    logic [15:0] cfg_sweep_len;
    logic [15:0] cfg_phase_offset;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        busy;
    logic        sweep_done;

    int checks = 0;
    int errors = 0;
    int takes = 0;
    int done_count = 0;
    int done_at = -1;

    logic [15:0] sb_q[$];
    logic [15:0] model_acc, model_freq, model_step, model_len, model_off, model_lfsr;

`ifdef DDS_PHASE_DITHER_EN
    localparam logic [3:0] EXP_LSB = 4'h1;
`else
    localparam logic [3:0] EXP_LSB = 4'h0;
`endif

    dds_phase_gen dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_freq            (cfg_freq),
        .cfg_freq_step       (cfg_freq_step),
        .cfg_sweep_len       (cfg_sweep_len),
        .cfg_phase_offset    (cfg_phase_offset),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .busy                (busy),
        .sweep_done          (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] modelDither(input logic [15:0] s);
`ifdef DDS_PHASE_DITHER_EN
        return {12'h000, s[3:0]};
`else
        return 16'h0000 & s;
`endif
    endfunction

    function automatic logic [15:0] modelWord();
        return model_acc + model_off + modelDither(model_lfsr);
    endfunction

    // Queue n expected words, advancing the reference phase/sweep state per word
    task automatic pushWords(input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(modelWord());
            model_acc = model_acc + model_freq;
            if (model_len != 16'h0) begin
                model_freq = model_freq + model_step;
                model_len  = model_len - 16'h1;
            end
            model_lfsr = {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge values are what the next edge sees
    always @(negedge clk) begin
        if (sweep_done) begin
            done_count++;
            done_at = takes;
        end
        if (tvalid && tready && !reset) begin
            checkOutput("sb_avail", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) checkOutput("tdata", 32'(tdata), 32'(sb_q.pop_front()));
            takes++;
        end
    end

    task automatic applyStimulus(input logic [15:0] f, input logic [15:0] st, input logic [15:0] len, input logic [15:0] off);
        checkOutput("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        cfg_freq = f; cfg_freq_step = st; cfg_sweep_len = len; cfg_phase_offset = off;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        model_acc = 16'h0; model_freq = f; model_step = st; model_len = len; model_off = off;
    endtask

    task automatic runTakes(input int n);
        int target;
        target = takes + n;
        tready = 1'b1;
        for (int c = 0; c < 200 && takes < target; c++) begin
            @(posedge clk); #1;
        end
        tready = 1'b0;
        checkOutput("take_count", 32'(takes), 32'(target));
    endtask

    task automatic stopAndDrain();
        enable = 1'b0;
        pushWords(1);
        @(posedge clk); #1;
        checkOutput("stop_hold_tvalid", 32'(tvalid), 32'd1);
        tready = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
        checkOutput("stop_tvalid_low", 32'(tvalid), 32'd0);
        checkOutput("stop_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("stop_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] held;
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; tready = 1'b0;
        cfg_freq = '0; cfg_freq_step = '0; cfg_sweep_len = '0; cfg_phase_offset = '0;
        model_lfsr = 16'hACE1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("rst_tdata", 32'(tdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sweep_done", 32'(sweep_done), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Constant tone with wrap after 0xF000
        $display("[TB] constant tone");
        applyStimulus(16'h1000, 16'h0000, 16'h0000, 16'h0000);
        done_count = 0;
        pushWords(18);
        enable = 1'b1;
        runTakes(18);
        checkOutput("tone_busy", 32'(busy), 32'd1);
        checkOutput("tone_cfg_ready", 32'(cfg_ready), 32'd0);
        checkOutput("tone_no_done", 32'(done_count), 32'd0);
        stopAndDrain();

        // Offset plus accumulator wrap
        $display("[TB] offset and wrap");
        applyStimulus(16'hC000, 16'h0000, 16'h0000, 16'h8000);
        pushWords(4);
        enable = 1'b1;
        runTakes(4);
        stopAndDrain();

        // Sweep of three samples, then steady final frequency
        $display("[TB] sweep");
        applyStimulus(16'h0100, 16'h0010, 16'h0003, 16'h0000);
        done_count = 0; done_at = -1;
        takes = 0;
        pushWords(7);
        enable = 1'b1;
        runTakes(7);
        checkOutput("sweep_done_pulses", 32'(done_count), 32'd1);
        checkOutput("sweep_done_after_take", 32'(done_at), 32'd3);
        stopAndDrain();

        // Backpressure mid-run, stop under backpressure, resume, ignored config
        $display("[TB] backpressure and stop");
        applyStimulus(16'h0345, 16'h0000, 16'h0000, 16'h0011);
        pushWords(3);
        enable = 1'b1;
        runTakes(3);
        held = modelWord();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_tdata_stable", 32'(tdata), 32'(held));
            checkOutput("bp_tvalid", 32'(tvalid), 32'd1);
        end
        stopAndDrain();
        pushWords(6);
        enable = 1'b1;
        runTakes(2);
        checkOutput("run_cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_freq = 16'h0001; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        runTakes(4);
        stopAndDrain();

        // Asynchronous reset in the middle of a sweep
        $display("[TB] reset mid-sweep");
        applyStimulus(16'h0200, 16'h0005, 16'h000A, 16'h1234);
        pushWords(4);
        enable = 1'b1;
        runTakes(4);
        @(posedge clk); #3;
        reset = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("async_tvalid", 32'(tvalid), 32'd0);
        checkOutput("async_tdata", 32'(tdata), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        sb_q.delete();
        @(posedge clk); #2;
        reset = 1'b0;
        model_acc = 16'h0; model_freq = 16'h0; model_step = 16'h0;
        model_len = 16'h0; model_off = 16'h0; model_lfsr = 16'hACE1;
        @(posedge clk); #1;
        pushWords(2);
        enable = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_tvalid", 32'(tvalid), 32'd1);
        checkOutput("post_reset_lsb", 32'(tdata[3:0]), 32'(EXP_LSB));
        runTakes(2);
        enable = 1'b0;

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
